// File: rtl/clb25_cfg_loader.sv
// Serial configuration loader for the clb25 CLB array: frames a serial bitstream into CFG words.
// Optional per-frame even parity bit is enabled by defining CLB25_CFG_PARITY_EN.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_SYNC   | counting consecutive 1s; four in a row arms the header
// S_HDR    | idle fill of 1s; the first 0 begins the preamble
// S_PRE    | remaining three preamble bits (expect 0,1,0)
// S_LEN    | shifting in the frame count N, MSB first
// S_FSTART | expecting frame start bit 0
// S_FDATA  | shifting CFG_W data bits into the holding register
// S_FPAR   | even parity bit over the data (parity build only)
// S_FSTOP  | expecting two 1 stop bits; the second one strobes the word
// S_DONE   | all frames loaded, input ignored until reset
// S_ERR    | framing/count/parity error, input ignored until reset
module clb25_cfg_loader #(
  parameter int CFG_W      = 37,
  parameter int CNT_W      = 8,
  parameter int MAX_FRAMES = 64
) (
  input  logic             K,
  input  logic             RST_N,
  input  logic             DIN,
  input  logic             DEN,
  output logic [CFG_W-1:0] CFG,
  output logic             CFG_VLD,
  output logic [CNT_W-1:0] CFG_ADDR,
  output logic             DONE,
  output logic             ERR
);

  localparam int BCW = $clog2((CFG_W > CNT_W) ? CFG_W : CNT_W);

  typedef enum logic [3:0] {
    S_SYNC,
    S_HDR,
    S_PRE,
    S_LEN,
    S_FSTART,
    S_FDATA,
    S_FPAR,
    S_FSTOP,
    S_DONE,
    S_ERR
  } state_t;

  state_t           state_q, state_d;
  logic [BCW-1:0]   bcnt_q, bcnt_d;
  logic [1:0]       ones_q, ones_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] nfr_q, nfr_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [CFG_W-1:0] hold_q, hold_d;
  logic [CFG_W-1:0] cfg_q, cfg_d;
  logic [CNT_W-1:0] addr_q, addr_d;
  logic             vld_q, vld_d;

  always_ff @(posedge K or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_SYNC;
      bcnt_q  <= '0;
      ones_q  <= '0;
      len_q   <= '0;
      nfr_q   <= '0;
      idx_q   <= '0;
      hold_q  <= '0;
      cfg_q   <= '0;
      addr_q  <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      ones_q  <= ones_d;
      len_q   <= len_d;
      nfr_q   <= nfr_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      cfg_q   <= cfg_d;
      addr_q  <= addr_d;
      vld_q   <= vld_d;
    end
  end

  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    ones_d  = ones_q;
    len_d   = len_q;
    nfr_d   = nfr_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    cfg_d   = cfg_q;
    addr_d  = addr_q;
    vld_d   = 1'b0;

    if (DEN) begin
      case (state_q)
        S_SYNC: begin
          if (DIN) begin
            if (ones_q == 2'd3) begin
              state_d = S_HDR;
              ones_d  = '0;
            end else begin
              ones_d = ones_q + 2'd1;
            end
          end else begin
            ones_d = '0;
          end
        end

        S_HDR: begin
          if (!DIN) begin
            state_d = S_PRE;
            bcnt_d  = BCW'(2);
          end
        end

        // Preamble tail is 0,1,0: only the middle bit (bcnt==1) is a 1.
        S_PRE: begin
          if (DIN != (bcnt_q == BCW'(1))) begin
            state_d = S_ERR;
          end else if (bcnt_q == '0) begin
            state_d = S_LEN;
            bcnt_d  = BCW'(CNT_W - 1);
          end else begin
            bcnt_d = bcnt_q - BCW'(1);
          end
        end

        S_LEN: begin
          len_d = {len_q[CNT_W-2:0], DIN};
          if (bcnt_q == '0) begin
            nfr_d = len_d;
            idx_d = '0;
            if (len_d == '0) begin
              state_d = S_DONE;
            end else if (len_d > CNT_W'(MAX_FRAMES)) begin
              state_d = S_ERR;
            end else begin
              state_d = S_FSTART;
            end
          end else begin
            bcnt_d = bcnt_q - BCW'(1);
          end
        end

        S_FSTART: begin
          if (DIN) begin
            state_d = S_ERR;
          end else begin
            state_d = S_FDATA;
            bcnt_d  = BCW'(CFG_W - 1);
          end
        end

        S_FDATA: begin
          hold_d = {hold_q[CFG_W-2:0], DIN};
          if (bcnt_q == '0) begin
`ifdef CLB25_CFG_PARITY_EN
            state_d = S_FPAR;
`else
            state_d = S_FSTOP;
            bcnt_d  = BCW'(1);
`endif
          end else begin
            bcnt_d = bcnt_q - BCW'(1);
          end
        end

`ifdef CLB25_CFG_PARITY_EN
        S_FPAR: begin
          if ((^hold_q) ^ DIN) begin
            state_d = S_ERR;
          end else begin
            state_d = S_FSTOP;
            bcnt_d  = BCW'(1);
          end
        end
`endif

        S_FSTOP: begin
          if (!DIN) begin
            state_d = S_ERR;
          end else if (bcnt_q != '0) begin
            bcnt_d = bcnt_q - BCW'(1);
          end else begin
            cfg_d  = hold_q;
            addr_d = idx_q;
            vld_d  = 1'b1;
            idx_d  = idx_q + CNT_W'(1);
            state_d = (idx_d == nfr_q) ? S_DONE : S_FSTART;
          end
        end

        default: ;
      endcase
    end
  end

  assign CFG      = cfg_q;
  assign CFG_VLD  = vld_q;
  assign CFG_ADDR = addr_q;
  assign DONE     = (state_q == S_DONE);
  assign ERR      = (state_q == S_ERR);

endmodule

// File: tb/tb_clb25_cfg_loader.sv
// Scoreboard bench for clb25_cfg_loader: stimulus pushes expected strobes, a monitor pops and checks.
// Expectations for the parity scenario follow CLB25_CFG_PARITY_EN.
module tb_clb25_cfg_loader;

  logic        K = 1'b0;
  logic        RST_N = 1'b0;
  logic        DIN = 1'b0;
  logic        DEN = 1'b0;
  logic [36:0] CFG;
  logic        CFG_VLD;
  logic [7:0]  CFG_ADDR;
  logic        DONE;
  logic        ERR;

  clb25_cfg_loader dut (
    .K        (K),
    .RST_N    (RST_N),
    .DIN      (DIN),
    .DEN      (DEN),
    .CFG      (CFG),
    .CFG_VLD  (CFG_VLD),
    .CFG_ADDR (CFG_ADDR),
    .DONE     (DONE),
    .ERR      (ERR)
  );

  always #5 K = ~K;

  typedef struct {
    logic [7:0]  addr;
    logic [36:0] data;
    logic        last;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;

  localparam logic [36:0] W_ONE = 37'h0_0101_6000;
  localparam logic [36:0] W_A   = 37'h1F_0000_0001;
  localparam logic [36:0] W_B   = 37'h0A_5A5A_5A5A;
  localparam logic [36:0] W_C   = 37'h10_F0F0_0F0E;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  // Monitor: every strobe must match the oldest outstanding expectation.
  always @(negedge K) begin
    if (RST_N === 1'b1 && CFG_VLD === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_strobe: got addr %0h cfg %0h expected no strobe", CFG_ADDR, CFG);
      end else begin
        mon_e = sb_q.pop_front();
        chk("strobe_cfg", 64'(CFG), 64'(mon_e.data));
        chk("strobe_addr", 64'(CFG_ADDR), 64'(mon_e.addr));
        chk("strobe_done", 64'(DONE), 64'(mon_e.last));
        chk("strobe_err", 64'(ERR), 64'd0);
      end
    end
  end

  task automatic push_exp(input logic [7:0] a, input logic [36:0] d, input logic l);
    exp_t e;
    e.addr = a;
    e.data = d;
    e.last = l;
    sb_q.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge K);
    RST_N = 1'b0;
    DEN   = 1'b0;
    DIN   = 1'b0;
    repeat (3) @(negedge K);
    sb_q.delete();
    RST_N = 1'b1;
  endtask

  task automatic bit1(input logic b);
    @(negedge K);
    DIN = b;
    DEN = 1'b1;
  endtask

  task automatic stall(input int n);
    repeat (n) begin
      @(negedge K);
      DEN = 1'b0;
      DIN = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic send_hdr(input logic [7:0] n, input logic [3:0] pre);
    repeat (8) bit1(1'b1);
    for (int i = 3; i >= 0; i--) bit1(pre[i]);
    for (int i = 7; i >= 0; i--) bit1(n[i]);
  endtask

  task automatic send_frame(input logic [36:0] d, input int stall_after, input logic bad_par);
    bit1(1'b0);
    for (int i = 36; i >= 0; i--) begin
      bit1(d[i]);
      if (i == stall_after) stall(5);
    end
`ifdef CLB25_CFG_PARITY_EN
    bit1((^d) ^ bad_par);
`else
    if (bad_par) stall(1);
`endif
    bit1(1'b1);
    bit1(1'b1);
  endtask

  task automatic check_end(string tag, logic e_done, logic e_err, logic [36:0] e_cfg, logic [7:0] e_addr);
    stall(4);
    chk({tag, "_pending"}, 64'(sb_q.size()), 64'd0);
    chk({tag, "_done"}, 64'(DONE), 64'(e_done));
    chk({tag, "_err"}, 64'(ERR), 64'(e_err));
    chk({tag, "_cfg"}, 64'(CFG), 64'(e_cfg));
    chk({tag, "_addr"}, 64'(CFG_ADDR), 64'(e_addr));
  endtask

  initial begin
    // Reset state
    do_reset();
    #1;
    chk("rst_cfg", 64'(CFG), 64'd0);
    chk("rst_vld", 64'(CFG_VLD), 64'd0);
    chk("rst_addr", 64'(CFG_ADDR), 64'd0);
    chk("rst_done", 64'(DONE), 64'd0);
    chk("rst_err", 64'(ERR), 64'd0);

    // Single frame load
    send_hdr(8'd1, 4'b0010);
    push_exp(8'd0, W_ONE, 1'b1);
    send_frame(W_ONE, -1, 1'b0);
    check_end("one", 1'b1, 1'b0, W_ONE, 8'd0);

    // Three frames with a DEN stall inside frame B's data
    do_reset();
    send_hdr(8'd3, 4'b0010);
    push_exp(8'd0, W_A, 1'b0);
    push_exp(8'd1, W_B, 1'b0);
    push_exp(8'd2, W_C, 1'b1);
    send_frame(W_A, -1, 1'b0);
    send_frame(W_B, 20, 1'b0);
    send_frame(W_C, -1, 1'b0);
    check_end("three", 1'b1, 1'b0, W_C, 8'd2);

    // Bad preamble, later valid traffic must be ignored
    do_reset();
    send_hdr(8'd1, 4'b0011);
    send_hdr(8'd1, 4'b0010);
    send_frame(W_A, -1, 1'b0);
    check_end("badpre", 1'b0, 1'b1, 37'd0, 8'd0);

    // Count over the limit
    do_reset();
    send_hdr(8'd65, 4'b0010);
    @(negedge K);
    DEN = 1'b0;
    chk("n65_err", 64'(ERR), 64'd1);
    chk("n65_done", 64'(DONE), 64'd0);

    // Count exactly at the limit is accepted
    do_reset();
    send_hdr(8'd64, 4'b0010);
    @(negedge K);
    DEN = 1'b0;
    chk("n64_err", 64'(ERR), 64'd0);
    chk("n64_done", 64'(DONE), 64'd0);

    // Zero frames
    do_reset();
    send_hdr(8'd0, 4'b0010);
    @(negedge K);
    DEN = 1'b0;
    chk("n0_done", 64'(DONE), 64'd1);
    chk("n0_err", 64'(ERR), 64'd0);
    check_end("n0", 1'b1, 1'b0, 37'd0, 8'd0);

    // Parity flipped on frame index 2
    do_reset();
    send_hdr(8'd3, 4'b0010);
    push_exp(8'd0, W_A, 1'b0);
    push_exp(8'd1, W_B, 1'b0);
`ifndef CLB25_CFG_PARITY_EN
    push_exp(8'd2, W_C, 1'b1);
`endif
    send_frame(W_A, -1, 1'b0);
    send_frame(W_B, -1, 1'b0);
    send_frame(W_C, -1, 1'b1);
`ifdef CLB25_CFG_PARITY_EN
    check_end("par", 1'b0, 1'b1, W_B, 8'd1);
`else
    check_end("par", 1'b1, 1'b0, W_C, 8'd2);
`endif

    // Asynchronous reset in the middle of frame 1's data
    do_reset();
    send_hdr(8'd2, 4'b0010);
    push_exp(8'd0, W_B, 1'b0);
    send_frame(W_B, -1, 1'b0);
    bit1(1'b0);
    for (int i = 36; i >= 27; i--) bit1(W_A[i]);
    #2;
    chk("pre_rst_cfg", 64'(CFG), 64'(W_B));
    RST_N = 1'b0;
    DEN   = 1'b0;
    #1;
    chk("mid_rst_cfg", 64'(CFG), 64'd0);
    chk("mid_rst_addr", 64'(CFG_ADDR), 64'd0);
    chk("mid_rst_vld", 64'(CFG_VLD), 64'd0);
    chk("mid_rst_done", 64'(DONE), 64'd0);
    chk("mid_rst_err", 64'(ERR), 64'd0);
    do_reset();
    send_hdr(8'd2, 4'b0010);
    push_exp(8'd0, W_C, 1'b0);
    push_exp(8'd1, W_A, 1'b1);
    send_frame(W_C, -1, 1'b0);
    send_frame(W_A, -1, 1'b0);
    check_end("reload", 1'b1, 1'b0, W_A, 8'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
